// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard. Each destination gets a countdown of the
// cycles until it leaves MEM; ID readers stall while a source is pending.
module reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 2,
   parameter int CNT_W    = 2,
   parameter int STALL_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                flush,
   input  logic                id_valid,
   input  logic                id_wb_en,
   input  logic [ADDR_W-1:0]   id_dest,
   input  logic [ADDR_W-1:0]   id_src1,
   input  logic [ADDR_W-1:0]   id_src2,
   input  logic                id_src2_used,
   output logic                hazard_detected,
   output logic                issue,
   output logic [NUM_REGS-1:0] pending_vec,
   output logic [STALL_W-1:0]  stall_count
);

   logic [CNT_W-1:0]   cnt_q [NUM_REGS];
   logic [CNT_W-1:0]   cnt_d [NUM_REGS];
   logic [STALL_W-1:0] stall_count_q;
   logic [STALL_W-1:0] stall_count_d;
   logic               src1_hit;
   logic               src2_hit;
   logic               load;

   always_comb begin
      pending_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         pending_vec[r] = (cnt_q[r] != '0);
      end
   end

   // Only prior state is consulted, so an instruction never stalls on itself.
   always_comb begin
      src1_hit        = (id_src1 != '0) && pending_vec[id_src1];
      src2_hit        = id_src2_used && (id_src2 != '0) && pending_vec[id_src2];
      hazard_detected = id_valid && (src1_hit || src2_hit);
      issue           = id_valid && !hazard_detected && !freeze && !flush;
      load            = issue && id_wb_en && (id_dest != '0);
   end

   // A fresh load overrides the decrement of an older writer to the same register.
   always_comb begin
      cnt_d = cnt_q;
      if (!freeze) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            if (load && (id_dest == ADDR_W'(r))) begin
               cnt_d[r] = CNT_W'(DEPTH);
            end
         end
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (hazard_detected && !freeze && !flush && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         stall_count_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule
